// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
//   uart_arb_state_t     - arbiter FSM state (IDLE, LOAD, SEND)
//   UART_BASE_FRAME_BITS - start + 8 data + 1 stop bit periods
//   UART_DIV_W           - width of the baud divisor and baud counter
//   uart_frame_bits()    - bit periods in one frame for a given format
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } uart_arb_state_t;

  localparam int UART_BASE_FRAME_BITS = 10;
  localparam int UART_DIV_W           = 12;

  // 10, 11 or 12 bit periods depending on parity and stop-bit count.
  function automatic logic [3:0] uart_frame_bits(input logic parity, input logic stop2);
    return 4'(UART_BASE_FRAME_BITS) + {3'b000, parity} + {3'b000, stop2};
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// uart_arb_pick: combinational round-robin picker.
// The search starts one past 'last' and wraps modulo NUM_REQ; the first
// requester found high wins. Driving 'last' with NUM_REQ-1 turns this into
// a fixed lowest-index-first priority picker.
//   req   - request vector
//   last  - index granted most recently
//   found - at least one request is high
//   idx   - winning requester index (0 when found is low)
module uart_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (!found && req[IDW'(cand)]) begin
        found = 1'b1;
        idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte
// requesters. The transmitter has no busy flag, so each frame is timed here
// from the latched baud divisor and frame format before the next byte goes out.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   req, req_data     - per-requester request and byte (byte k at [8k+7:8k])
//   parity_sel, stop_sel, baud_divisor - frame format, latched on IDLE->LOAD
//   ack               - one-cycle accept pulse for the granted requester
//   grant_id          - requester owning the current frame
//   busy              - high in LOAD and SEND
//   tx_valid, tx_data, tx_parity_sel, tx_stop_sel - to the transmitter
//   fsm_state         - current FSM state for observation
//
// Configuration macro UART_TX_ARB_FIXED_PRIO_EN: when defined, lowest index
// always wins; otherwise round-robin. Timing is identical in both modes.
//
// Handshake: req[k] is held high with req_data stable until ack[k] pulses
// for one cycle (the LOAD cycle); tx_valid pulses in that same cycle and the
// transmitter is given no further pulse until FRAME_BITS*D SEND cycles pass.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_data,
  input  logic                    parity_sel,
  input  logic                    stop_sel,
  input  logic [UART_DIV_W-1:0]   baud_divisor,
  output logic [NUM_REQ-1:0]      ack,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_parity_sel,
  output logic                    tx_stop_sel,
  output uart_arb_state_t         fsm_state
);

  uart_arb_state_t         state, next_state;
  logic [IDW-1:0]          pick_last;
  logic [IDW-1:0]          pick_idx;
  logic                    pick_found;
  logic                    take;
  logic [UART_DIV_W-1:0]   div_q;
  logic [UART_DIV_W-1:0]   baud_cnt;
  logic [3:0]              bit_cnt;
  logic [3:0]              frame_bits;
  logic                    baud_last;
  logic                    frame_done;

  assign take = (state == IDLE) && pick_found;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Searching from index 0 every time gives lowest-index priority.
  assign pick_last = IDW'(NUM_REQ - 1);
`else
  logic [IDW-1:0] last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    last_grant <= IDW'(NUM_REQ - 1);
    else if (take) last_grant <= pick_idx;
  end

  assign pick_last = last_grant;
`endif

  uart_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req   (req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Frame timer runs off the latched format so mid-frame input changes
  // cannot stretch or cut the frame in flight.
  assign frame_bits = uart_frame_bits(tx_parity_sel, tx_stop_sel);
  assign baud_last  = (baud_cnt == div_q - 12'd1);
  assign frame_done = baud_last && (bit_cnt == frame_bits - 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ack        = '0;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (pick_found) next_state = LOAD;
      LOAD: begin
        tx_valid   = 1'b1;
        ack        = NUM_REQ'(1) << grant_id;
        busy       = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (frame_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id      <= '0;
      tx_data       <= '0;
      tx_parity_sel <= 1'b0;
      tx_stop_sel   <= 1'b0;
      div_q         <= '0;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
    end else begin
      if (take) begin
        grant_id      <= pick_idx;
        tx_data       <= req_data[8*pick_idx +: 8];
        tx_parity_sel <= parity_sel;
        tx_stop_sel   <= stop_sel;
        // A zero divisor would never complete a baud period; run it as 1.
        div_q         <= (baud_divisor == '0) ? 12'd1 : baud_divisor;
      end
      if (state == LOAD) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == SEND) begin
        if (baud_last) begin
          baud_cnt <= '0;
          if (!frame_done) bit_cnt <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 12'd1;
        end
      end
    end
  end

endmodule
